// File: rtl/am_pkg.sv
// rtl/am_pkg.sv - alignment-marker tables, compare masks and FSM state type
package am_pkg;

    localparam int AM_BLOCK_W = 66;

    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Compared fields: sync header, M0..M2 and M4..M6; BIP3/BIP7 are don't-care
    localparam logic [AM_BLOCK_W-1:0] AM_CMP_MASK =
        {8'h00, 24'hff_ffff, 8'h00, 24'hff_ffff, 2'b11};
    localparam logic [AM_BLOCK_W-1:0] AM_BIP_MASK =
        {8'hff, 24'h00_0000, 8'hff, 24'h00_0000, 2'b00};

    function automatic logic [AM_BLOCK_W-1:0] am_word(
        input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2,
        input logic [7:0] m4, input logic [7:0] m5, input logic [7:0] m6);
        return {8'h00, m6, m5, m4, 8'h00, m2, m1, m0, SYNC_CTRL};
    endfunction

    localparam logic [AM_BLOCK_W-1:0] AM_40G_TABLE [4] = '{
        am_word(8'h90, 8'h76, 8'h47, 8'h6f, 8'h89, 8'hb8),
        am_word(8'hf0, 8'hc4, 8'he6, 8'h0f, 8'h3b, 8'h19),
        am_word(8'hc5, 8'h65, 8'h9b, 8'h3a, 8'h9a, 8'h64),
        am_word(8'ha2, 8'h79, 8'h3d, 8'h5d, 8'h86, 8'hc2)
    };

    localparam logic [AM_BLOCK_W-1:0] AM_100G_TABLE [20] = '{
        am_word(8'hc1, 8'h68, 8'h21, 8'h3e, 8'h97, 8'hde),
        am_word(8'h9d, 8'h71, 8'h8e, 8'h62, 8'h8e, 8'h71),
        am_word(8'h59, 8'h4b, 8'he8, 8'ha6, 8'hb4, 8'h17),
        am_word(8'h4d, 8'h95, 8'h7b, 8'hb2, 8'h6a, 8'h84),
        am_word(8'hf5, 8'h07, 8'h09, 8'h0a, 8'hf8, 8'hf6),
        am_word(8'hdd, 8'h14, 8'hc2, 8'h22, 8'heb, 8'h3d),
        am_word(8'h9a, 8'h4a, 8'h26, 8'h65, 8'hb5, 8'hd9),
        am_word(8'h7b, 8'h45, 8'h66, 8'h84, 8'hba, 8'h99),
        am_word(8'ha0, 8'h24, 8'h76, 8'h5f, 8'hdb, 8'h89),
        am_word(8'h68, 8'hc9, 8'hfb, 8'h97, 8'h36, 8'h04),
        am_word(8'hfd, 8'h6c, 8'h99, 8'h02, 8'h93, 8'h66),
        am_word(8'hb9, 8'h91, 8'h55, 8'h46, 8'h6e, 8'haa),
        am_word(8'h5c, 8'hb9, 8'hb2, 8'ha3, 8'h46, 8'h4d),
        am_word(8'h1a, 8'hf8, 8'hbd, 8'he5, 8'h07, 8'h42),
        am_word(8'h83, 8'hc7, 8'hca, 8'h7c, 8'h38, 8'h35),
        am_word(8'h35, 8'h36, 8'hcd, 8'hca, 8'hc9, 8'h32),
        am_word(8'hc4, 8'h31, 8'h4c, 8'h3b, 8'hce, 8'hb3),
        am_word(8'had, 8'hd6, 8'hb7, 8'h52, 8'h29, 8'h48),
        am_word(8'h5f, 8'h66, 8'h2a, 8'ha0, 8'h99, 8'hd5),
        am_word(8'hc0, 8'hf0, 8'he5, 8'h3f, 8'h0f, 8'h1a)
    };

    typedef enum logic [3:0] {
        ST_INVALID = 4'b0001,
        ST_SYNC    = 4'b0010,
        ST_FIRST   = 4'b0100,
        ST_LOCK    = 4'b1000
    } am_state_t;

endpackage

// File: rtl/am_match.sv
// rtl/am_match.sv - masked compare of one block against one alignment marker
import am_pkg::*;

module am_match #(
    parameter int BLOCK_W = 66
) (
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [BLOCK_W-1:0] marker_i,
    output logic               match_o
);

    assign match_o = (((block_i ^ marker_i) & AM_CMP_MASK) == '0);

endmodule

// File: rtl/am_lock_n_rx.sv
// rtl/am_lock_n_rx.sv - per-lane alignment-marker lock FSM with bit-slip request
import am_pkg::*;

module am_lock_n_rx #(
    parameter int AM_N    = 4,
    parameter int GAP_N   = 16383,
    parameter int NV_MAX  = 4,
    parameter int BLOCK_W = 66
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    valid_i,
    input  logic [BLOCK_W-1:0]      block_i,
    output logic                    lock_v_o,
    output logic                    slip_v_o,
    output logic                    am_v_o,
    output logic                    lite_am_v_o,
    output logic                    lite_lock_v_o,
    output logic [AM_N-1:0]         lane_o,
    output logic [$clog2(AM_N)-1:0] lane_idx_o
);

    localparam int IDX_W = $clog2(AM_N);
    localparam int GAP_W = $clog2(GAP_N + 1);

    if (!(AM_N == 4 || AM_N == 20)) begin : g_bad_am_n
        $error("am_lock_n_rx: AM_N must be 4 or 20");
    end
    if (NV_MAX < 1 || NV_MAX > 15) begin : g_bad_nv_max
        $error("am_lock_n_rx: NV_MAX must be in 1..15");
    end
    if (BLOCK_W != AM_BLOCK_W) begin : g_bad_block_w
        $error("am_lock_n_rx: BLOCK_W must be 66");
    end

    logic [AM_N-1:0]  w_match;
    logic             w_any;
    logic [IDX_W-1:0] w_first_idx;
    logic             w_lane_hit;
    logic             w_at_gap;

    for (genvar g = 0; g < AM_N; g++) begin : g_match
        logic [BLOCK_W-1:0] w_marker;
        if (AM_N == 4) begin : g_40g
            assign w_marker = AM_40G_TABLE[g];
        end else begin : g_100g
            assign w_marker = AM_100G_TABLE[g];
        end
        am_match #(.BLOCK_W(BLOCK_W)) u_match (
            .block_i  (block_i),
            .marker_i (w_marker),
            .match_o  (w_match[g])
        );
    end

    logic [IDX_W-1:0] r_lane_idx;
    logic [AM_N-1:0]  r_lane;
    logic [GAP_W-1:0] r_gap;
    logic [3:0]       r_nv_cnt;
    am_state_t        r_state;
    logic             r_lock;
    logic             r_slip;
    logic             r_am;
    logic             r_lite_am;
    logic             r_lite_lock;

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        w_first_idx = '0;
        for (int i = AM_N - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_first_idx = IDX_W'(i);
            end
        end
    end

    assign w_any      = |w_match;
    assign w_lane_hit = w_match[r_lane_idx];
    assign w_at_gap   = (r_gap == GAP_W'(GAP_N));

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= ST_INVALID;
            r_lane_idx  <= '0;
            r_lane      <= '0;
            r_gap       <= '0;
            r_nv_cnt    <= '0;
            r_lock      <= 1'b0;
            r_slip      <= 1'b0;
            r_am        <= 1'b0;
            r_lite_am   <= 1'b0;
            r_lite_lock <= 1'b0;
        end else begin
            r_slip    <= 1'b0;
            r_am      <= 1'b0;
            r_lite_am <= valid_i & w_any;
            if (!valid_i) begin
                r_state     <= ST_INVALID;
                r_lane_idx  <= '0;
                r_lane      <= '0;
                r_gap       <= '0;
                r_nv_cnt    <= '0;
                r_lock      <= 1'b0;
                r_lite_lock <= 1'b0;
            end else begin
                case (r_state)
                    ST_INVALID, ST_SYNC: begin
                        r_gap <= '0;
                        if (w_any) begin
                            r_state     <= ST_FIRST;
                            r_lane_idx  <= w_first_idx;
                            r_lane      <= {{(AM_N-1){1'b0}}, 1'b1} << w_first_idx;
                            r_lite_lock <= 1'b1;
                        end else begin
                            r_state <= ST_SYNC;
                        end
                    end
                    ST_FIRST: begin
                        if (w_at_gap) begin
                            r_gap <= '0;
                            if (w_lane_hit) begin
                                r_state  <= ST_LOCK;
                                r_nv_cnt <= '0;
                                r_am     <= 1'b1;
                                r_lock   <= 1'b1;
                            end else begin
                                r_state     <= ST_SYNC;
                                r_slip      <= 1'b1;
                                r_lane_idx  <= '0;
                                r_lane      <= '0;
                                r_lite_lock <= 1'b0;
                            end
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    ST_LOCK: begin
                        if (w_at_gap) begin
                            r_gap <= '0;
                            if (w_lane_hit) begin
                                r_nv_cnt <= '0;
                                r_am     <= 1'b1;
                            end else if (r_nv_cnt + 4'd1 >= 4'(NV_MAX)) begin
                                r_state     <= ST_SYNC;
                                r_slip      <= 1'b1;
                                r_nv_cnt    <= '0;
                                r_lane_idx  <= '0;
                                r_lane      <= '0;
                                r_lock      <= 1'b0;
                                r_lite_lock <= 1'b0;
                            end else begin
                                r_nv_cnt <= r_nv_cnt + 4'd1;
                            end
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_INVALID;
                        r_gap   <= '0;
                    end
                endcase
            end
        end
    end

    assign lock_v_o      = r_lock;
    assign slip_v_o      = r_slip;
    assign am_v_o        = r_am;
    assign lite_am_v_o   = r_lite_am;
    assign lite_lock_v_o = r_lite_lock;
    assign lane_o        = r_lane;
    assign lane_idx_o    = r_lane_idx;

endmodule

// File: tb/tb_am_lock_n_rx.sv
// tb/tb_am_lock_n_rx.sv - directed bench for am_lock_n_rx (40G and 100G tables)
module tb_am_lock_n_rx;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        v4 = 1'b1;
    logic [65:0] b4 = {64'h0, 2'b01};
    logic        v20 = 1'b1;
    logic [65:0] b20 = {64'h0, 2'b01};

    logic        lock4, slip4, am4, lam4, llock4;
    logic [3:0]  lane4;
    logic [1:0]  idx4;
    logic        lock20, slip20, am20, lam20, llock20;
    logic [19:0] lane20;
    logic [4:0]  idx20;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    am_lock_n_rx #(.AM_N(4), .GAP_N(7), .NV_MAX(4), .BLOCK_W(66)) dut4 (
        .clk(clk), .nreset(nreset), .valid_i(v4), .block_i(b4),
        .lock_v_o(lock4), .slip_v_o(slip4), .am_v_o(am4), .lite_am_v_o(lam4),
        .lite_lock_v_o(llock4), .lane_o(lane4), .lane_idx_o(idx4)
    );

    am_lock_n_rx #(.AM_N(20), .GAP_N(7), .NV_MAX(4), .BLOCK_W(66)) dut20 (
        .clk(clk), .nreset(nreset), .valid_i(v20), .block_i(b20),
        .lock_v_o(lock20), .slip_v_o(slip20), .am_v_o(am20), .lite_am_v_o(lam20),
        .lite_lock_v_o(llock20), .lane_o(lane20), .lane_idx_o(idx20)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] mk(input logic [7:0] m0, input logic [7:0] m1,
                                       input logic [7:0] m2, input logic [7:0] m4,
                                       input logic [7:0] m5, input logic [7:0] m6);
        logic [7:0] bip3 = 8'($urandom);
        logic [7:0] bip7 = 8'($urandom);
        return {bip7, m6, m5, m4, bip3, m2, m1, m0, 2'b10};
    endfunction

    function automatic logic [65:0] dat();
        return {32'($urandom), 32'($urandom), 2'b01};
    endfunction

    function automatic logic [65:0] l0();  return mk(8'h90, 8'h76, 8'h47, 8'h6f, 8'h89, 8'hb8); endfunction
    function automatic logic [65:0] l0b(); return mk(8'h90, 8'h76, 8'h47, 8'h6f, 8'h88, 8'hb8); endfunction
    function automatic logic [65:0] l1();  return mk(8'hf0, 8'hc4, 8'he6, 8'h0f, 8'h3b, 8'h19); endfunction
    function automatic logic [65:0] l2();  return mk(8'hc5, 8'h65, 8'h9b, 8'h3a, 8'h9a, 8'h64); endfunction
    function automatic logic [65:0] l3();  return mk(8'ha2, 8'h79, 8'h3d, 8'h5d, 8'h86, 8'hc2); endfunction
    function automatic logic [65:0] h19(); return mk(8'hc0, 8'hf0, 8'he5, 8'h3f, 8'h0f, 8'h1a); endfunction

    task automatic send(input logic v, input logic [65:0] b);
        @(negedge clk);
        v4 = v;
        b4 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send20(input logic v, input logic [65:0] b);
        @(negedge clk);
        v20 = v;
        b20 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic gap7();
        repeat (7) send(1'b1, dat());
    endtask

    // outputs packed as {lock, slip, am, lite_am, lite_lock, lane[3:0], idx[1:0]}
    function automatic logic [31:0] o4();
        return {21'd0, lock4, slip4, am4, lam4, llock4, lane4, idx4};
    endfunction

    initial begin
        // Reset and plain data
        send(1'b1, dat());
        send(1'b1, dat());
        chk("reset_outputs", o4(), 32'h0);
        chk("reset_outputs_100g", {lock20, slip20, am20, lam20, llock20, lane20, idx20}, 32'h0);
        @(negedge clk);
        nreset = 1'b1;
        send(1'b1, dat());
        send(1'b1, dat());
        chk("data_only", o4(), 32'h0);

        // Lane 2 acquire and confirm
        send(1'b1, l2());
        chk("l2_first", o4(), {21'd0, 5'b00011, 4'b0100, 2'd2});
        gap7();
        chk("l2_gap_no_pulse", {slip4, am4, lock4, llock4}, 4'b0001);
        send(1'b1, l2());
        chk("l2_lock", o4(), {21'd0, 5'b10111, 4'b0100, 2'd2});
        send(1'b1, dat());
        chk("l2_am_once", {lock4, am4, slip4}, 3'b100);

        // Wrong lane at confirmation
        send(1'b0, dat());
        chk("invalid_drop", o4(), 32'h0);
        send(1'b1, l2());
        chk("l2_first_again", {llock4, lane4}, {1'b1, 4'b0100});
        gap7();
        send(1'b1, l1());
        chk("wrong_lane_slip", o4(), {21'd0, 5'b01010, 4'b0000, 2'd0});
        send(1'b1, dat());
        chk("slip_single", {slip4, lock4, llock4}, 3'b000);

        // Lock on lane 0, three bad then a good marker
        send(1'b1, l0());
        gap7();
        send(1'b1, l0());
        chk("l0_lock", o4(), {21'd0, 5'b10111, 4'b0001, 2'd0});
        for (int i = 0; i < 3; i++) begin
            gap7();
            send(1'b1, l0b());
            chk("bad_hold", {lock4, slip4, am4}, 3'b100);
        end
        gap7();
        send(1'b1, l0());
        chk("good_after_3bad", {lock4, slip4, am4}, 3'b101);

        // Four consecutive bad (first is a valid lane-3 marker)
        gap7();
        send(1'b1, l3());
        chk("other_lane_bad", {lock4, slip4, am4, lam4}, 4'b1001);
        for (int i = 0; i < 2; i++) begin
            gap7();
            send(1'b1, l0b());
            chk("bad_hold2", {lock4, slip4}, 2'b10);
        end
        gap7();
        send(1'b1, l0b());
        chk("nv_max_slip", o4(), {21'd0, 5'b01000, 4'b0000, 2'd0});
        send(1'b1, dat());
        chk("nv_slip_single", {slip4, lock4}, 2'b00);

        // valid_i drop mid-gap, then relock
        send(1'b1, l0());
        gap7();
        send(1'b1, l0());
        chk("relock", {lock4, am4}, 2'b11);
        repeat (3) send(1'b1, dat());
        send(1'b0, dat());
        chk("valid_low_drop", o4(), 32'h0);
        send(1'b1, l0());
        chk("relock_first", {lock4, llock4, lane4}, {2'b01, 4'b0001});
        gap7();
        send(1'b1, l0());
        chk("relock_confirm", {lock4, am4, slip4}, 3'b110);

        // 100G table, lane 19
        send20(1'b1, h19());
        chk("h19_first", {lock20, llock20, lane20, idx20}, {2'b01, 20'h80000, 5'd19});
        repeat (7) send20(1'b1, dat());
        send20(1'b1, h19());
        chk("h19_lock", {lock20, am20, slip20, lane20, idx20}, {3'b110, 20'h80000, 5'd19});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/am_lock_n_rx.md
# am_lock_n_rx

Parametrised alignment-marker lock for multi-lane BASE-R receive: one instance per PCS lane. It finds the periodic alignment marker on the lane, identifies which logical lane it carries, confirms it one period later and holds lock until NV_MAX consecutive expected markers fail. It sits between block sync and deskew, and supports both 40G (4 markers) and 100G (20 markers) tables. A bit-slip request goes back to block sync on every lock failure.

## Interface
- AM_N, 4: number of markers in the table. Only 4 (40GBASE-R table) and 20 (100GBASE-R table) are legal; any other value is an elaboration error.
- GAP_N, 16383: data blocks between two consecutive markers on a lane.
- NV_MAX, 4: consecutive bad expected markers that cause loss of lock. Legal range is 1..15.
- BLOCK_W, 66: block width.
- clk  in  1  clock.
- nreset  in  1  synchronous active-low reset.
- valid_i  in  1  block_i valid; low means the block stream is invalid (not a stall).
- block_i  in  BLOCK_W  66b block, sync header in [1:0].
- lock_v_o  out  1  marker lock held (state LOCK).
- slip_v_o  out  1  one-cycle pulse requesting a bit slip.
- am_v_o  out  1  one-cycle pulse: expected marker accepted (FIRST→LOCK, or in LOCK).
- lite_am_v_o  out  1  current block matched any table marker.
- lite_lock_v_o  out  1  state is FIRST or LOCK.
- lane_o  out  AM_N  one-hot logical lane; all zeros when not FIRST/LOCK.
- lane_idx_o  out  $clog2(AM_N)  binary lane index; 0 when not FIRST/LOCK.

## Operation
- One-hot FSM with states INVALID, SYNC, FIRST, LOCK.
- Marker compare covers sync header [1:0]==2'b10, M0..M2 at [25:2] and M4..M6 at [57:34]. BIP3 [33:26] and BIP7 [65:58] are ignored.
- Match vector is computed against all AM_N markers. If more than one matches, the lowest index wins.
- The gap counter has width $clog2(GAP_N+1). It increments on each valid block. The expected marker position is when gap==GAP_N. The counter resets to 0 on a marker accept/compare and on entry to SYNC/INVALID.
- valid_i==0 in any state moves the FSM to INVALID, clears gap, nv_cnt and lane, and has priority over every other event.
- INVALID: the next valid block moves the FSM to SYNC. That block is also compared, so a marker on it moves the FSM directly to FIRST.
- SYNC: any match moves the FSM to FIRST, latches the lane and sets gap=0. No match keeps the FSM in SYNC with no slip.
- FIRST: at gap==GAP_N the block is compared against the latched lane only.
  - Match: go to LOCK, nv_cnt=0, pulse am_v_o.
  - Mismatch: pulse slip_v_o, go to SYNC, clear the lane.
- LOCK: at each expected position the block is compared against the latched lane.
  - Match: nv_cnt=0, pulse am_v_o.
  - Mismatch: nv_cnt+1. If the result equals NV_MAX, pulse slip_v_o, go to SYNC, clear the lane and nv_cnt.
- nv_cnt width is 4 bits and it saturates at NV_MAX (never wraps).
- A correct marker of a different lane at the expected position counts as a mismatch.

## Timing
- All outputs are registered. A decision made on the block of cycle N is visible on cycle N+1.
- Reset values:
  - state=INVALID.
  - lock_v_o, slip_v_o, am_v_o, lite_am_v_o, lite_lock_v_o = 0.
  - lane_o=0, lane_idx_o=0.
  - gap=0, nv_cnt=0.
- slip_v_o and am_v_o last exactly one cycle and never assert together.
- lock_v_o rises in the cycle after the confirming marker. It falls in the cycle after the NV_MAXth bad marker, or after valid_i low.
- Reset mid-lock has the same effect as the reset values above, with no slip pulse.

## Structure
- Package am_pkg holds:
  - SYNC_CTRL.
  - The compare bit masks.
  - AM_40G_TABLE[4] and AM_100G_TABLE[20] as BLOCK_W-wide constants.
  - An FSM state enum.
- Sub-module am_match: combinational compare of block_i against one table entry. Instantiate it AM_N times with generate.
- Lane-select compare uses the latched lane_idx to mux the match vector.

## Test plan
All scenarios use AM_N=4, GAP_N=7, NV_MAX=4 unless stated. Lane 0 marker (40G) is bytes 0x90,0x76,0x47 / 0x6f,0x89,0xb8. Lane 2 marker is 0xc5,0x65,0x9b / 0x3a,0x9a,0x64.

1. Reset, then valid_i=1 with data → all outputs 0, no lite_am_v_o, no slip.
2. Lane 2 marker, 7 data blocks, lane 2 marker → lite_lock_v_o=1 after the first marker and lane_o=4'b0100. After the second marker: lock_v_o=1, am_v_o pulses once, lane_idx_o=2. Random BIP bytes are used throughout.
3. Lane 2 marker, 7 data blocks, lane 1 marker → slip_v_o single pulse, lock_v_o stays 0, lane_o=0, FSM back in SYNC.
4. Locked on lane 0: 3 corrupted markers then a good one → lock_v_o stays 1, am_v_o pulses on the good one. Then 4 consecutive corrupted markers → slip_v_o pulses and lock_v_o drops in the cycle after the 4th.
5. Locked: valid_i=0 for one cycle mid-gap → lock_v_o=0 next cycle, no slip. Relock needs two fresh markers 8 blocks apart.
6. AM_N=20, GAP_N=7: 100G lane 19 marker twice, 8 blocks apart → lock_v_o=1, lane_idx_o=19, lane_o[19]=1.
